// File: rtl/pe_result_serializer_if.sv
// Beat stream interface from the PE result serializer to the writeback/buffer path.
interface pe_result_serializer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pe_result_serializer.sv
// Snapshots the PE array result on pe_done and streams it out as LANES-wide beats.
// Optional macro SER_RELU_EN: negative words are emitted as zero (buffer keeps raw values).
module pe_result_serializer #(
  parameter int NUM_PE = 64,
  parameter int DATA_W = 16,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PE*DATA_W-1:0] pe_result,
  input  logic                     pe_done,
  output logic                     cap_ready,
  pe_result_serializer_if.master   beat,
  output logic                     busy,
  output logic [7:0]               frame_cnt,
  output logic                     overrun_err,
  input  logic                     err_clr
);

  localparam int BEATS = NUM_PE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                    state;
  logic [BW-1:0]             beat_idx;
  logic [BW-1:0]             next_idx;
  logic [NUM_PE*DATA_W-1:0]  buf_q;
  logic                      capture;

  function automatic logic [LANES*DATA_W-1:0] beat_of(
    input logic [NUM_PE*DATA_W-1:0] v,
    input logic [BW-1:0]            b
  );
    logic [LANES*DATA_W-1:0] r;
    r = v[b*LANES*DATA_W +: LANES*DATA_W];
`ifdef SER_RELU_EN
    for (int unsigned l = 0; l < LANES; l++) begin
      if (r[l*DATA_W + DATA_W - 1]) r[l*DATA_W +: DATA_W] = '0;
    end
`endif
    return r;
  endfunction

  assign next_idx  = beat_idx + 1'b1;
  assign cap_ready = (state == IDLE) || (state == DRAIN && beat.out_last && beat.out_ready);
  assign capture   = pe_done && cap_ready;

  // Buffer has no reset; its contents only matter once a capture has happened.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= pe_result;
  end

  // On capture, beat 0 is taken straight from pe_result since buf_q updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat_idx       <= '0;
      beat.out_valid <= 1'b0;
      beat.out_last  <= 1'b0;
      beat.out_data  <= '0;
      busy           <= 1'b0;
      frame_cnt      <= '0;
      overrun_err    <= 1'b0;
    end else begin
      if (pe_done && !cap_ready) overrun_err <= 1'b1;
      else if (err_clr)          overrun_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pe_done) begin
            state          <= DRAIN;
            beat_idx       <= '0;
            beat.out_valid <= 1'b1;
            beat.out_last  <= (LAST_IDX == '0);
            beat.out_data  <= beat_of(pe_result, '0);
            busy           <= 1'b1;
          end
        end
        DRAIN: begin
          if (beat.out_ready) begin
            if (beat_idx == LAST_IDX) begin
              frame_cnt <= frame_cnt + 8'd1;
              if (pe_done) begin
                beat_idx      <= '0;
                beat.out_last <= (LAST_IDX == '0);
                beat.out_data <= beat_of(pe_result, '0);
              end else begin
                state          <= IDLE;
                beat_idx       <= '0;
                beat.out_valid <= 1'b0;
                beat.out_last  <= 1'b0;
                beat.out_data  <= '0;
                busy           <= 1'b0;
              end
            end else begin
              beat_idx      <= next_idx;
              beat.out_last <= (next_idx == LAST_IDX);
              beat.out_data <= beat_of(buf_q, next_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
